polyvec_unpack_buffer: RTL and testbench

- Downstream consumer of the state-unpack stage. Captures its 64-beat polyvec write stream: 128-bit words, each holding 8 lanes of 16-bit coefficients, two shares in parallel.
- Holds the complete polyvec (K=2, N=256) in an internal register array.
- Once the set is captured, replays it in address order to the NTT/matrix stage over a valid/ready stream.
- Decouples the free-running unpack writer from a back-pressuring consumer; same path for encryption (pk) and decryption (masked sk).

---
 rtl/polyvec_unpack_buffer_pkg.sv | 19 +
 rtl/polyvec_unpack_buffer_csubq.sv | 13 +
 rtl/polyvec_unpack_buffer.sv | 160 ++++++++++++++++
 tb/tb_polyvec_unpack_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyvec_unpack_buffer_pkg.sv
// Shared constants and state encoding for the polyvec unpack buffer.
package polyvec_unpack_buffer_pkg;
  localparam int KYBER_K = 2;
  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int LANE_W  = 16;
  localparam int LANES   = 8;
  localparam int LENGTH  = LANES * LANE_W;
  localparam int DEPTH   = KYBER_K * KYBER_N * LANE_W / LENGTH;
  localparam int AW      = $clog2(DEPTH);

  localparam logic [LANE_W-1:0] Q_LANE = LANE_W'(KYBER_Q);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/polyvec_unpack_buffer_csubq.sv
// polyvec_lane_csubq: 8-lane conditional subtract of q, purely combinational.
module polyvec_lane_csubq
  import polyvec_unpack_buffer_pkg::*;
(
  input  logic [LENGTH-1:0] din_i,
  output logic [LENGTH-1:0] dout_o
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] v;
    assign v = din_i[g*LANE_W +: LANE_W];
    assign dout_o[g*LANE_W +: LANE_W] = (v >= Q_LANE) ? v - Q_LANE : v;
  end
endmodule

// File: rtl/polyvec_unpack_buffer.sv
// Captures a 64-word two-share polyvec and replays it in address order on a valid/ready stream.
// Optional output-lane reduction mod q when POLYVEC_BUF_CSUBQ_EN is defined.
//   state    | meaning
//   ST_IDLE  | waiting for start; writes flag overrun
//   ST_FILL  | capturing words until bitmap full or in_done
//   ST_DRAIN | presenting words 0..DEPTH-1 to the consumer
module polyvec_unpack_buffer
  import polyvec_unpack_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [AW-1:0]     in_addr,
  input  logic [LENGTH-1:0] in_data1,
  input  logic [LENGTH-1:0] in_data2,
  input  logic              in_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_addr,
  output logic [LENGTH-1:0] out_data1,
  output logic [LENGTH-1:0] out_data2,
  output logic              out_last,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_incomplete
);
  state_e            state_q, state_d;
  logic [DEPTH-1:0]  bm_q, bm_d, bm_set;
  logic              ovr_q, ovr_d, inc_q, inc_d;
  logic              ov_q, ov_d, last_q, last_d;
  logic [AW-1:0]     addr_q, addr_d, rd_addr;
  logic [LENGTH-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [LENGTH-1:0] raw1, raw2, red1, red2;
  logic              mem_we, load;

  logic [LENGTH-1:0] mem1_q [DEPTH];
  logic [LENGTH-1:0] mem2_q [DEPTH];

  assign bm_set = bm_q | (DEPTH'(1) << in_addr);
  assign raw1   = mem1_q[rd_addr];
  assign raw2   = mem2_q[rd_addr];

`ifdef POLYVEC_BUF_CSUBQ_EN
  polyvec_lane_csubq u_csubq1 (.din_i(raw1), .dout_o(red1));
  polyvec_lane_csubq u_csubq2 (.din_i(raw2), .dout_o(red2));
`else
  assign red1 = raw1;
  assign red2 = raw2;
`endif

  always_comb begin
    state_d = state_q;
    bm_d    = bm_q;
    ovr_d   = ovr_q;
    inc_d   = inc_q;
    ov_d    = ov_q;
    last_d  = last_q;
    addr_d  = addr_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    mem_we  = 1'b0;
    load    = 1'b0;
    rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) ovr_d = 1'b1;
      end
      ST_FILL: begin
        if (!start) begin
          if (in_valid) begin
            mem_we = 1'b1;
            bm_d   = bm_set;
          end
          if ((&bm_d) || in_done) state_d = ST_DRAIN;
          if (in_done && !(&bm_d)) inc_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (in_valid) ovr_d = 1'b1;
        if (!ov_q) begin
          load    = 1'b1;
          rd_addr = '0;
        end else if (out_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
            last_d  = 1'b0;
          end else begin
            load    = 1'b1;
            rd_addr = addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      ov_d   = 1'b1;
      addr_d = rd_addr;
      last_d = (rd_addr == AW'(DEPTH - 1));
      d1_d   = red1;
      d2_d   = red2;
    end

    // start from any state restarts capture and wins over everything else this cycle
    if (start) begin
      state_d = ST_FILL;
      bm_d    = '0;
      ovr_d   = 1'b0;
      inc_d   = 1'b0;
      ov_d    = 1'b0;
      last_d  = 1'b0;
      addr_d  = addr_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bm_q    <= '0;
      ovr_q   <= 1'b0;
      inc_q   <= 1'b0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      bm_q    <= bm_d;
      ovr_q   <= ovr_d;
      inc_q   <= inc_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem1_q[in_addr] <= in_data1;
      mem2_q[in_addr] <= in_data2;
    end
  end

  assign out_valid      = ov_q;
  assign out_last       = last_q;
  assign out_addr       = addr_q;
  assign out_data1      = d1_q;
  assign out_data2      = d2_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_overrun    = ovr_q;
  assign err_incomplete = inc_q;
endmodule

// File: tb/tb_polyvec_unpack_buffer.sv
// Scoreboard bench for polyvec_unpack_buffer; honours POLYVEC_BUF_CSUBQ_EN when defined.
module tb_polyvec_unpack_buffer;
  import polyvec_unpack_buffer_pkg::*;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic              in_valid = 1'b0, in_done = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]     in_addr = '0;
  logic [LENGTH-1:0] in_data1 = '0, in_data2 = '0;
  logic              out_valid, out_last, busy, err_overrun, err_incomplete;
  logic [AW-1:0]     out_addr;
  logic [LENGTH-1:0] out_data1, out_data2;

  always #5 clk = ~clk;

  polyvec_unpack_buffer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_addr(in_addr),
    .in_data1(in_data1), .in_data2(in_data2), .in_done(in_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data1(out_data1), .out_data2(out_data2),
    .out_last(out_last), .busy(busy), .err_overrun(err_overrun), .err_incomplete(err_incomplete)
  );

  typedef struct packed {
    logic [AW-1:0]     a;
    logic [LENGTH-1:0] d1;
    logic [LENGTH-1:0] d2;
    logic              last;
  } exp_t;

  exp_t              sb[$];
  logic [LENGTH-1:0] m1 [DEPTH];
  logic [LENGTH-1:0] m2 [DEPTH];
  int                n_chk = 0, n_fail = 0;
  logic              use_pat = 1'b0;
  logic              rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [LENGTH-1:0] word0_seen = '0, word5_seen = '0;
  logic              hold_chk = 1'b0;
  exp_t              held;

  task automatic chk(input string nm, input logic [LENGTH-1:0] act, input logic [LENGTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [LENGTH-1:0] red(input logic [LENGTH-1:0] w);
    logic [LENGTH-1:0] r;
    r = w;
`ifdef POLYVEC_BUF_CSUBQ_EN
    for (int l = 0; l < LANES; l++)
      if (w[l*16 +: 16] >= 16'd3329) r[l*16 +: 16] = w[l*16 +: 16] - 16'd3329;
`endif
    return r;
  endfunction

  function automatic logic [LENGTH-1:0] pat(input int a);
    logic [LENGTH-1:0] w;
    logic [5:0]        aa;
    logic [2:0]        ll;
    aa = a[5:0];
    w  = '0;
    for (int l = 0; l < LANES; l++) begin
      ll = l[2:0];
      w[l*16 +: 16] = {4'h0, aa, 3'b000, ll};
    end
    return w;
  endfunction

  // monitor: pops one expected word per handshake, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk && out_valid) begin
        chk("hold_addr", LENGTH'(out_addr), LENGTH'(held.a));
        chk("hold_d1", out_data1, held.d1);
        chk("hold_d2", out_data2, held.d2);
      end
      hold_chk = 1'b0;
      if (out_valid) chkb("last_vs_addr", out_last, out_addr == AW'(DEPTH - 1));
      if (out_valid && !out_ready) begin
        held     = '{out_addr, out_data1, out_data2, out_last};
        hold_chk = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got addr %h expected no word", out_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_addr", LENGTH'(out_addr), LENGTH'(e.a));
          chk("sb_d1", out_data1, e.d1);
          chk("sb_d2", out_data2, e.d2);
          chkb("sb_last", out_last, e.last);
          if (out_addr == 0) word0_seen = out_data1;
          if (out_addr == 5) word5_seen = out_data1;
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [LENGTH-1:0] d1,
                    input logic [LENGTH-1:0] d2, input logic done);
    in_valid = 1'b1; in_addr = a; in_data1 = d1; in_data2 = d2; in_done = done;
    m1[a] = d1;
    m2[a] = d2;
    @(posedge clk); #1;
    in_valid = 1'b0; in_done = 1'b0;
  endtask

  task automatic push_all();
    for (int i = 0; i < DEPTH; i++)
      sb.push_back('{AW'(i), red(m1[i]), red(m2[i]), i == DEPTH - 1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_std(input logic [LENGTH-1:0] x);
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), pat(a) ^ x, ~(pat(a) ^ x), a == DEPTH - 1);
    push_all();
  endtask

  task automatic drain(input string nm, input int inj);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      out_ready = use_pat ? rdy_pat[c % 4] : 1'b1;
      in_valid  = (c == inj);
      in_addr   = AW'(5);
      in_data1  = {LENGTH{1'b1}};
      in_data2  = {LENGTH{1'b1}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    out_ready = 1'b0;
    chkb({nm, "_drain_done"}, ok, 1'b1);
    chkb({nm, "_busy_low"}, busy, 1'b0);
    chkb({nm, "_valid_low"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [LENGTH-1:0] w0, w0_exp;
    #12;
    chkb("rst_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_last", out_last, 1'b0);
    chkb("rst_ovr", err_overrun, 1'b0);
    chkb("rst_inc", err_incomplete, 1'b0);
    chk("rst_addr", LENGTH'(out_addr), '0);
    chk("rst_d1", out_data1, '0);
    chk("rst_d2", out_data2, '0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // in-order fill, full-rate drain
    pulse_start();
    chkb("t1_busy_fill", busy, 1'b1);
    fill_std('0);
    chkb("t1_busy_drain", busy, 1'b1);
    drain("t1", -1);
    chkb("t1_ovr", err_overrun, 1'b0);
    chkb("t1_inc", err_incomplete, 1'b0);

    // back-pressure pattern 1,0,0,1
    pulse_start();
    fill_std({8{16'h0101}});
    use_pat = 1'b1;
    drain("t2", -1);
    use_pat = 1'b0;

    // reverse order with duplicate write to address 5
    pulse_start();
    for (int a = DEPTH - 1; a >= 5; a--) wr(AW'(a), pat(a) ^ {8{16'h0202}}, pat(a), 1'b0);
    wr(AW'(5), 128'hA, '0, 1'b0);
    for (int a = 4; a >= 0; a--) wr(AW'(a), pat(a) ^ {8{16'h0202}}, pat(a), a == 0);
    push_all();
    drain("t3", -1);
    chk("t3_word5", word5_seen, 128'hA);
    chkb("t3_inc", err_incomplete, 1'b0);

    // early in_done after 40 writes; words 40..63 keep t3 contents
    pulse_start();
    for (int a = 0; a < 40; a++) wr(AW'(a), pat(a) ^ {8{16'h0303}}, ~pat(a), 1'b0);
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
    push_all();
    chkb("t4_inc_set", err_incomplete, 1'b1);
    drain("t4", -1);
    chkb("t4_inc_sticky", err_incomplete, 1'b1);
    chkb("t4_ovr", err_overrun, 1'b0);

    // overrun from IDLE and mid-DRAIN; array must be untouched
    in_valid = 1'b1; in_addr = AW'(7); in_data1 = '1; in_data2 = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chkb("t5_ovr_idle", err_overrun, 1'b1);
    chkb("t5_idle_busy", busy, 1'b0);
    pulse_start();
    chkb("t5_ovr_clr", err_overrun, 1'b0);
    fill_std({8{16'h0404}});
    drain("t5", 10);
    chkb("t5_ovr_drain", err_overrun, 1'b1);

    // lane reduction vector in word 0
    pulse_start();
    w0 = {16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd4095, 16'd3329, 16'd3328};
`ifdef POLYVEC_BUF_CSUBQ_EN
    w0_exp = {16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd766, 16'd0, 16'd3328};
`else
    w0_exp = w0;
`endif
    wr(AW'(0), w0, w0, 1'b0);
    for (int a = 1; a < DEPTH; a++) wr(AW'(a), pat(a), pat(a), a == DEPTH - 1);
    push_all();
    drain("t6", -1);
    chk("t6_word0_lanes", word0_seen, w0_exp);

    // asynchronous reset mid-DRAIN, then fresh fill
    pulse_start();
    fill_std({8{16'h0606}});
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chkb("t7_rst_valid", out_valid, 1'b0);
    chkb("t7_rst_busy", busy, 1'b0);
    chkb("t7_rst_last", out_last, 1'b0);
    chk("t7_rst_d1", out_data1, '0);
    out_ready = 1'b0;
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    fill_std({8{16'h0707}});
    drain("t7", -1);
    chkb("t7_ovr", err_overrun, 1'b0);
    chkb("t7_inc", err_incomplete, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
